// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the bit serializer.
// Optional feature macro: SER_PARITY_EN (appends an even-parity bit to each frame).
package ser_pkg;

    typedef enum logic [0:0] {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_t;

    // Bits per frame: data bits plus the optional parity bit.
    function automatic int frame_len(input int width);
`ifdef SER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

    // Counter width; wide enough to hold WIDTH (the parity-frame load value).
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out bundle of the bit serializer.
// Handshake: a word transfers on a rising edge where in_valid && in_ready;
// in_ready never depends on in_valid, and in_data/lsb_first are only
// meaningful in that accept cycle. dbg_* exposes FSM state and bit counter.
interface bit_serializer_if #(
    parameter int WIDTH = 8
) ();
    localparam int CW = ser_pkg::cnt_width(WIDTH);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             lsb_first;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;
    logic [0:0]       dbg_state;
    logic [CW-1:0]    dbg_count;

    modport master (
        output in_data, in_valid, lsb_first,
        input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy,
        input  dbg_state, dbg_count
    );

    modport slave (
        input  in_data, in_valid, lsb_first,
        output in_ready, ser_out, ser_valid, ser_first, ser_last, busy,
        output dbg_state, dbg_count
    );
endinterface

// File: rtl/bit_serializer_counter.sv
// Down-counter tracking the remaining bits of the current frame.
// Load has priority over decrement; the count parks at zero.
module ser_bit_counter #(
    parameter int CW       = 4,
    parameter int LOAD_VAL = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_dec,
    output logic [CW-1:0] o_count,
    output logic          o_is_first,
    output logic          o_is_zero
);
    logic [CW-1:0] r_cnt;

    // Load at frame start, count down once per emitted bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CW'(LOAD_VAL);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign o_count    = r_cnt;
    assign o_is_first = (r_cnt == CW'(LOAD_VAL));
    assign o_is_zero  = (r_cnt == '0);
endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word in, one bit per clock out
// with first/last framing flags. Back-to-back words give a gap-free stream.
// Optional feature macro: SER_PARITY_EN (even-parity bit closes each frame).
module bit_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    bit_serializer_if.slave  bus
);
    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CW        = cnt_width(WIDTH);

    // Encodings match ser_state_t.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_ser_out;
`ifdef SER_PARITY_EN
    logic             r_parity;
`endif

    logic             w_shift;
    logic             w_last;
    logic             w_ready;
    logic             w_accept;
    logic             w_is_first;
    logic             w_is_zero;
    logic             w_next_bit;
    logic [CW-1:0]    w_count;
    logic [WIDTH-1:0] w_word;

    assign w_shift  = (r_state == ST_SHIFT);
    assign w_last   = w_shift && w_is_zero;
    assign w_ready  = !w_shift || w_last;
    assign w_accept = bus.in_valid && w_ready;

    // Orient the word so the first bit to send always sits at the MSB;
    // this is how the bit order is captured at accept time.
    always_comb begin
        w_word = bus.in_data;
        if (bus.lsb_first) begin
            for (int i = 0; i < WIDTH; i++) begin
                w_word[i] = bus.in_data[WIDTH-1-i];
            end
        end
    end

    // Bit that follows the current one within the frame.
`ifdef SER_PARITY_EN
    assign w_next_bit = (w_count == CW'(1)) ? r_parity : r_shreg[WIDTH-2];
`else
    assign w_next_bit = r_shreg[WIDTH-2];
`endif

    ser_bit_counter #(
        .CW       (CW),
        .LOAD_VAL (FRAME_LEN - 1)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_accept),
        .i_dec      (w_shift && !w_accept),
        .o_count    (w_count),
        .o_is_first (w_is_first),
        .o_is_zero  (w_is_zero)
    );

    // FSM, shift register and registered serial bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_ser_out <= 1'b0;
        end else if (w_accept) begin
            r_state   <= ST_SHIFT;
            r_shreg   <= w_word;
            r_ser_out <= w_word[WIDTH-1];
        end else if (w_last) begin
            r_state   <= ST_IDLE;
            r_shreg   <= '0;
            r_ser_out <= 1'b0;
        end else if (w_shift) begin
            r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
            r_ser_out <= w_next_bit;
        end
    end

`ifdef SER_PARITY_EN
    // Even parity of the accepted word, emitted after the data bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_accept) begin
            r_parity <= ^bus.in_data;
        end
    end
`endif

    assign bus.in_ready  = w_ready;
    assign bus.ser_out   = r_ser_out;
    assign bus.ser_valid = w_shift;
    assign bus.ser_first = w_shift && w_is_first;
    assign bus.ser_last  = w_last;
    assign bus.busy      = w_shift;
    assign bus.dbg_state = r_state;
    assign bus.dbg_count = w_count;
endmodule

// File: tb/tb_bit_serializer.sv
// Directed self-checking bench for bit_serializer (WIDTH = 8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bit_serializer;
`ifdef SER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [0:0] exp_q[$];

    bit_serializer_if #(.WIDTH(8)) bus ();

    bit_serializer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Present a word for one cycle (caller ensures in_ready), then scramble in_data.
    task automatic drive_accept(input logic [7:0] word, input logic lsb);
        bus.in_data   = word;
        bus.lsb_first = lsb;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'($urandom_range(0, 255));
        bus.lsb_first = 1'($urandom_range(0, 1));
    endtask

    // Record n cycles of outputs, one bit per cycle, index 0 = current cycle.
    task automatic capture(input int n, output logic [31:0] so, output logic [31:0] sv,
                           output logic [31:0] sf, output logic [31:0] sl,
                           output logic [31:0] rd, output logic [31:0] bz);
        so = '0; sv = '0; sf = '0; sl = '0; rd = '0; bz = '0;
        for (int i = 0; i < n; i++) begin
            so[i] = bus.ser_out;
            sv[i] = bus.ser_valid;
            sf[i] = bus.ser_first;
            sl[i] = bus.ser_last;
            rd[i] = bus.in_ready;
            bz[i] = bus.busy;
            @(negedge clk);
        end
    endtask

    // Push the hand-computed bit sequence (seq[7] goes first) plus parity bit.
    task automatic push_frame(input logic [7:0] seq, input logic par);
        for (int i = 7; i >= 0; i--) exp_q.push_back(seq[i]);
`ifdef SER_PARITY_EN
        exp_q.push_back(par);
`else
        if (par === 1'bx) exp_q.push_back(1'b0);
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.ser_out !== 1'b0)   begin errors++; $display("FAIL reset_ser_out: got %b want 0", bus.ser_out); end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL reset_ser_valid: got %b want 0", bus.ser_valid); end
        checks++; if (bus.ser_first !== 1'b0) begin errors++; $display("FAIL reset_ser_first: got %b want 0", bus.ser_first); end
        checks++; if (bus.ser_last !== 1'b0)  begin errors++; $display("FAIL reset_ser_last: got %b want 0", bus.ser_last); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b want 0", bus.dbg_state); end
        checks++; if (bus.dbg_count !== '0)   begin errors++; $display("FAIL reset_count: got %0d want 0", bus.dbg_count); end
        rst_n = 1'b1;
    endtask

    task automatic test_msb_first();
        logic [31:0] so, sv, sf, sl, rd, bz;
        logic [0:0]  e;
        logic        alt_ok;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL msb_ready_idle: got %b want 1", bus.in_ready); end
        push_frame(8'b1010_1010, 1'b0);
        drive_accept(8'hAA, 1'b0);
        capture(FL + 1, so, sv, sf, sl, rd, bz);
        for (int i = 0; i < FL; i++) begin
            e = exp_q.pop_front();
            checks++; if (so[i] !== e) begin errors++; $display("FAIL msb_bit%0d: got %b want %b", i, so[i], e); end
        end
        alt_ok = 1'b1;
        for (int i = 1; i < 8; i++) if (so[i] === so[i-1]) alt_ok = 1'b0;
        checks++; if (alt_ok !== 1'b1) begin errors++; $display("FAIL msb_alternation: got %b want 1", alt_ok); end
        checks++; if (sf !== 32'd1) begin errors++; $display("FAIL msb_first_flag: got %h want %h", sf, 32'd1); end
        checks++; if (sl !== (32'd1 << (FL-1))) begin errors++; $display("FAIL msb_last_flag: got %h want %h", sl, 32'd1 << (FL-1)); end
        checks++; if (sv !== ((32'd1 << FL) - 1)) begin errors++; $display("FAIL msb_valid: got %h want %h", sv, (32'd1 << FL) - 1); end
        checks++; if (bz !== ((32'd1 << FL) - 1)) begin errors++; $display("FAIL msb_busy: got %h want %h", bz, (32'd1 << FL) - 1); end
        checks++; if (rd !== ((32'd3) << (FL-1))) begin errors++; $display("FAIL msb_ready: got %h want %h", rd, 32'd3 << (FL-1)); end
        checks++; if (so[FL] !== 1'b0) begin errors++; $display("FAIL msb_idle_out: got %b want 0", so[FL]); end
    endtask

    task automatic test_lsb_first();
        logic [31:0] so, sv, sf, sl, rd, bz;
        logic [0:0]  e;
        push_frame(8'b1000_1101, 1'b0);
        drive_accept(8'hB1, 1'b1);
        capture(FL + 1, so, sv, sf, sl, rd, bz);
        for (int i = 0; i < FL; i++) begin
            e = exp_q.pop_front();
            checks++; if (so[i] !== e) begin errors++; $display("FAIL lsb_bit%0d: got %b want %b", i, so[i], e); end
        end
        checks++; if (sl !== (32'd1 << (FL-1))) begin errors++; $display("FAIL lsb_last_flag: got %h want %h", sl, 32'd1 << (FL-1)); end
        checks++; if (sv !== ((32'd1 << FL) - 1)) begin errors++; $display("FAIL lsb_valid: got %h want %h", sv, (32'd1 << FL) - 1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] so, sv, sf, sl, rd;
        logic [0:0]  e;
        logic [31:0] want_rd;
        int sent;
        so = '0; sv = '0; sf = '0; sl = '0; rd = '0; sent = 0;
        push_frame(8'b0101_0101, 1'b0);
        push_frame(8'b0000_1111, 1'b0);
        bus.in_data = 8'h55; bus.lsb_first = 1'b0; bus.in_valid = 1'b1;
        for (int c = 0; c < 2*FL + 2; c++) begin
            logic acc;
            so[c] = bus.ser_out; sv[c] = bus.ser_valid; sf[c] = bus.ser_first;
            sl[c] = bus.ser_last; rd[c] = bus.in_ready;
            acc = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (acc) sent++;
            if (sent == 1) bus.in_data = 8'h0F;
            if (sent >= 2) bus.in_valid = 1'b0;
        end
        checks++; if (sent !== 2) begin errors++; $display("FAIL b2b_accepts: got %0d want 2", sent); end
        for (int i = 1; i <= 2*FL; i++) begin
            e = exp_q.pop_front();
            checks++; if (so[i] !== e) begin errors++; $display("FAIL b2b_bit%0d: got %b want %b", i - 1, so[i], e); end
        end
        want_rd = 32'd1 | (32'd1 << FL) | (32'd3 << (2*FL));
        checks++; if (rd !== want_rd) begin errors++; $display("FAIL b2b_ready: got %h want %h", rd, want_rd); end
        checks++; if (sv !== (((32'd1 << (2*FL)) - 1) << 1)) begin errors++; $display("FAIL b2b_valid: got %h want %h", sv, ((32'd1 << (2*FL)) - 1) << 1); end
        checks++; if (sf !== (32'd2 | (32'd2 << FL))) begin errors++; $display("FAIL b2b_first: got %h want %h", sf, 32'd2 | (32'd2 << FL)); end
        checks++; if (sl !== ((32'd1 << FL) | (32'd1 << (2*FL)))) begin errors++; $display("FAIL b2b_last: got %h want %h", sl, (32'd1 << FL) | (32'd1 << (2*FL))); end
    endtask

    task automatic test_backpressure();
        logic [31:0] so, rd;
        logic [0:0]  e;
        so = '0; rd = '0;
        push_frame(8'b1100_0011, 1'b0);
        drive_accept(8'hC3, 1'b0);
        for (int k = 0; k < FL; k++) begin
            so[k] = bus.ser_out;
            rd[k] = bus.in_ready;
            bus.in_valid = (k < FL - 1);
            bus.in_data  = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            e = exp_q.pop_front();
            checks++; if (so[i] !== e) begin errors++; $display("FAIL bp_bit%0d: got %b want %b", i, so[i], e); end
        end
        checks++; if (rd !== (32'd1 << (FL-1))) begin errors++; $display("FAIL bp_ready: got %h want %h", rd, 32'd1 << (FL-1)); end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL bp_no_accept: got %b want 0", bus.ser_valid); end
        checks++; if (bus.dbg_state !== 1'b0) begin errors++; $display("FAIL bp_state: got %b want 0", bus.dbg_state); end
        @(negedge clk);
    endtask

`ifdef SER_PARITY_EN
    task automatic test_parity();
        logic [31:0] so, sv, sf, sl, rd, bz;
        drive_accept(8'hB0, 1'b0);
        capture(FL + 1, so, sv, sf, sl, rd, bz);
        checks++; if (so[8:0] !== 9'b1_0000_1101) begin errors++; $display("FAIL par_b0_bits: got %b want %b", so[8:0], 9'b1_0000_1101); end
        checks++; if (sl !== 32'h100) begin errors++; $display("FAIL par_b0_last: got %h want 00000100", sl); end
        checks++; if (sv !== 32'h1FF) begin errors++; $display("FAIL par_b0_valid: got %h want 000001ff", sv); end
        drive_accept(8'hC0, 1'b0);
        capture(FL + 1, so, sv, sf, sl, rd, bz);
        checks++; if (so[8] !== 1'b0) begin errors++; $display("FAIL par_c0_bit: got %b want 0", so[8]); end
        checks++; if (so[7:0] !== 8'b0000_0011) begin errors++; $display("FAIL par_c0_data: got %b want 00000011", so[7:0]); end
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [31:0] so, sv, sf, sl, rd, bz;
        logic [0:0]  e;
        drive_accept(8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (bus.ser_valid !== 1'b1 || bus.ser_out !== 1'b1) begin errors++; $display("FAIL rmf_before: got valid=%b out=%b want 1/1", bus.ser_valid, bus.ser_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.ser_out !== 1'b0)   begin errors++; $display("FAIL rmf_ser_out: got %b want 0", bus.ser_out); end
        checks++; if (bus.ser_valid !== 1'b0) begin errors++; $display("FAIL rmf_ser_valid: got %b want 0", bus.ser_valid); end
        checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rmf_busy: got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL rmf_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.dbg_count !== '0)   begin errors++; $display("FAIL rmf_count: got %0d want 0", bus.dbg_count); end
        @(negedge clk);
        rst_n = 1'b1;
        push_frame(8'b1000_0001, 1'b0);
        drive_accept(8'h81, 1'b0);
        capture(FL + 1, so, sv, sf, sl, rd, bz);
        for (int i = 0; i < FL; i++) begin
            e = exp_q.pop_front();
            checks++; if (so[i] !== e) begin errors++; $display("FAIL rmf_bit%0d: got %b want %b", i, so[i], e); end
        end
        checks++; if (sf !== 32'd1) begin errors++; $display("FAIL rmf_first: got %h want 00000001", sf); end
        checks++; if (sv !== ((32'd1 << FL) - 1)) begin errors++; $display("FAIL rmf_valid: got %h want %h", sv, (32'd1 << FL) - 1); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.lsb_first = 1'b0;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_back_to_back();
        test_backpressure();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the bit-stream checker chain. Accepts a `WIDTH`-bit word over a valid/ready handshake and emits it one bit per clock on a serial output, with framing flags. It sits directly upstream of the sequence-checking FSM, which samples `ser_out` every clock. Back-to-back words produce a gap-free bit stream.

## Interface
- `WIDTH`, default 8: word width in bits; legal range ≥ 2.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_data`  in  WIDTH: parallel word; sampled on the accept edge.
- `in_valid`  in  1: `in_data` is valid.
- `in_ready`  out  1: block can accept a word this cycle.
- `lsb_first`  in  1: bit order, sampled on the accept edge. 0 sends MSB first; 1 sends LSB first.
- `ser_out`  out  1: serial data bit.
- `ser_valid`  out  1: `ser_out` carries a frame bit this cycle.
- `ser_first`  out  1: current bit is the first bit of a frame.
- `ser_last`  out  1: current bit is the last bit of a frame (the parity bit when parity is enabled).
- `busy`  out  1: a frame is in progress; equal to `ser_valid`.

## Operation
- **States:** IDLE and SHIFT.
- **Accept:** an accept occurs when `in_valid && in_ready` is true at a rising edge. On accept:
  - the word is loaded into the shift register;
  - `lsb_first` is latched;
  - the bit counter is set to `FRAME_LEN - 1`;
  - the state goes to SHIFT.
- **Frame length:** `FRAME_LEN = WIDTH`, or `WIDTH + 1` with parity enabled.
- **SHIFT:** each cycle presents one bit on `ser_out` with `ser_valid` = 1. At the edge the register shifts and the counter decrements.
- **Flags:**
  - `ser_first` = 1 on the cycle the counter equals `FRAME_LEN - 1`.
  - `ser_last` = 1 on the cycle the counter equals 0.
- **Leaving SHIFT:** on the edge that ends the `ser_last` cycle:
  - with no accept on that edge, the state returns to IDLE;
  - with an accept on that edge, the state stays in SHIFT with the new word. There is no idle cycle between frames.
- **`in_ready`:** combinational, `(state == IDLE) || ser_last`. It does not depend on `in_valid`.
- **Holding off:** `in_valid` asserted while `in_ready` = 0 is ignored. `in_data` need not be held after the accept.
- **Idle outputs:** in IDLE, `ser_out`, `ser_valid`, `ser_first`, `ser_last` and `busy` are all 0.
- **Reset:**
  - `ser_out`, `ser_valid`, `ser_first`, `ser_last`, `busy`, the shift register and the counter are 0; the state is IDLE.
  - `in_ready` is 1 as soon as `rst_n` is low.
  - Reset asserted mid-frame aborts the frame immediately (asynchronously). No partial resumption.
- **Width rules:** the counter is `$clog2(WIDTH+1)` bits. The shift register is `WIDTH` bits. Serial bits are registered outputs, not combinational from `in_data`.

## Timing
- **Latency:** accept at edge N gives the first bit valid in cycle N+1. Bit k is valid in cycle N+1+k.
- **Throughput:** one word per `FRAME_LEN` cycles when the source keeps `in_valid` high.
- **Output registering:** `ser_out`, `ser_valid`, `ser_first` and `ser_last` change only on `clk` edges or on `rst_n` assertion.
- **Reset release:** first accept is possible on the first rising edge after `rst_n` deasserts.

## Configuration
- **`SER_PARITY_EN` defined:** after the `WIDTH` data bits, one extra bit is emitted, the even-parity bit (XOR of all data bits). `ser_last` marks the parity bit, and `FRAME_LEN = WIDTH + 1`.
- **`SER_PARITY_EN` undefined:** there is no parity bit, the last data bit carries `ser_last`, and `FRAME_LEN = WIDTH`.

## Structure
- **Shared package `ser_pkg`:**
  - state enum `ser_state_t` (IDLE, SHIFT);
  - localparam function for `FRAME_LEN` given `WIDTH`;
  - counter width helper.
- **Sub-modules:** one is natural, `ser_bit_counter`. It is a down-counter with load, decrement, and `is_first`/`is_zero` flags. The rest is a single flat module.

## Test plan
- **Basic MSB-first frame:** reset, then `in_data` = 8'hAA, `lsb_first` = 0, one accept. Expect `ser_out` = 1,0,1,0,1,0,1,0 in cycles N+1..N+8, `ser_first` only in N+1, `ser_last` only in N+8, then IDLE. A downstream alternation checker's output stays 1.
- **LSB-first frame:** 8'hB1 with `lsb_first` = 1. Expect `ser_out` = 1,0,0,0,1,1,0,1.
- **Back-to-back:** 8'h55 then 8'h0F with `in_valid` held high. Expect `in_ready` high only in IDLE and in `ser_last` cycles, 16 consecutive valid bits, and the second `ser_first` in the cycle right after the first `ser_last`.
- **Backpressure:** change `in_data` while `busy` with `in_valid` = 1 and `in_ready` = 0. Expect no accept and the current frame bits unchanged.
- **Parity (`SER_PARITY_EN`):** 8'hB0 (three 1s). Expect 9 bits with the 9th = 1 and `ser_last` on it. For 8'hC0 the 9th bit = 0.
- **Reset mid-frame:** drop `rst_n` during bit 4 of 8'hFF. Expect outputs 0 immediately and `in_ready` = 1. After release, a new word 8'h81 serializes cleanly from its first bit.
